// File: rtl/sd_cmd_axi_master.sv
// sd_cmd_axi_master
//   Drives an SD-controller register window over AXI4-Lite to issue one SD
//   command: five command bytes are pushed to tx_cmd (BASE+0x00), each gated
//   by a tx-full status poll, then cmd_resp_len response bytes are pulled from
//   rx_cmd (BASE+0x04), each gated by an rx-empty status poll (BASE+0x10).
//   Status bit5 (no disk) aborts; POLL_LIMIT consecutive busy polls time out.
// Ports
//   M_AXI_ACLK / M_AXI_ARESETN : clock, async active-low reset
//   M_AXI_AW*/W*/B*/AR*/R*     : AXI4-Lite master, one transaction at a time
//   cmd_start/index/arg/resp_len : command request, sampled only when idle
//   busy, done, err, resp      : status, completion pulse, error code, response
module sd_cmd_axi_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT = 1023
) (
  input  logic         M_AXI_ACLK,
  input  logic         M_AXI_ARESETN,
  output logic [31:0]  M_AXI_AWADDR,
  output logic         M_AXI_AWVALID,
  input  logic         M_AXI_AWREADY,
  output logic [31:0]  M_AXI_WDATA,
  output logic [3:0]   M_AXI_WSTRB,
  output logic         M_AXI_WVALID,
  input  logic         M_AXI_WREADY,
  input  logic [1:0]   M_AXI_BRESP,
  input  logic         M_AXI_BVALID,
  output logic         M_AXI_BREADY,
  output logic [31:0]  M_AXI_ARADDR,
  output logic         M_AXI_ARVALID,
  input  logic         M_AXI_ARREADY,
  input  logic [31:0]  M_AXI_RDATA,
  input  logic [1:0]   M_AXI_RRESP,
  input  logic         M_AXI_RVALID,
  output logic         M_AXI_RREADY,
  input  logic         cmd_start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [4:0]   cmd_resp_len,
  output logic         busy,
  output logic         done,
  output logic [1:0]   err,
  output logic [135:0] resp
);

  localparam int unsigned PW = (POLL_LIMIT < 1) ? 1 : $clog2(POLL_LIMIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK_TX, S_WRITE, S_CHK_RX, S_READ, S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [5:0]     idx_q, idx_d;
  logic [31:0]    arg_q, arg_d;
  logic [4:0]     len_q, len_d;
  logic [2:0]     wr_cnt_q, wr_cnt_d;
  logic [4:0]     rd_cnt_q, rd_cnt_d;
  logic [PW-1:0]  poll_q, poll_d;
  logic [1:0]     err_q, err_d;
  logic [135:0]   resp_q, resp_d;
  logic           awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic           arvalid_q, arvalid_d, rready_q, rready_d;
  logic [31:0]    awaddr_q, awaddr_d, wdata_q, wdata_d, araddr_q, araddr_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic [7:0]     tx_byte;
  logic           stat_busy;

  // Response codes and upper data bits carry nothing this block acts on.
  logic unused_ok;
  assign unused_ok = ^{M_AXI_BRESP, M_AXI_RRESP, M_AXI_RDATA[31:8]};

  always_comb begin
    case (wr_cnt_q)
      3'd1:    tx_byte = arg_q[31:24];
      3'd2:    tx_byte = arg_q[23:16];
      3'd3:    tx_byte = arg_q[15:8];
      3'd4:    tx_byte = arg_q[7:0];
      default: tx_byte = {2'b01, idx_q};
    endcase
  end

  // tx path waits on "tx full" (bit0), rx path on "rx empty" (bit1).
  assign stat_busy = (state_q == S_CHK_RX) ? M_AXI_RDATA[1] : M_AXI_RDATA[0];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    arg_d     = arg_q;
    len_d     = len_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    poll_d    = poll_q;
    err_d     = err_q;
    resp_d    = resp_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    araddr_d  = araddr_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          idx_d    = cmd_index;
          arg_d    = cmd_arg;
          len_d    = (cmd_resp_len > 5'd17) ? 5'd17 : cmd_resp_len;
          resp_d   = '0;
          wr_cnt_d = '0;
          rd_cnt_d = '0;
          poll_d   = '0;
          err_d    = 2'b00;
          state_d  = S_CHK_TX;
        end
      end
      // All three read-based states share one AR -> R sequence: launch when
      // nothing is in flight, then AR handshake, then R handshake.
      S_CHK_TX, S_CHK_RX, S_READ: begin
        if (!arvalid_q && !rready_q) begin
          arvalid_d = 1'b1;
          araddr_d  = (state_q == S_READ) ? BASE_ADDR + 32'h04 : BASE_ADDR + 32'h10;
        end else if (arvalid_q) begin
          if (M_AXI_ARREADY) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
          end
        end else if (M_AXI_RVALID) begin
          rready_d = 1'b0;
          if (state_q == S_READ) begin
            resp_d   = {resp_q[127:0], M_AXI_RDATA[7:0]};
            rd_cnt_d = rd_cnt_q + 5'd1;
            state_d  = (rd_cnt_d >= len_q) ? S_DONE : S_CHK_RX;
          end else if (M_AXI_RDATA[5]) begin
            err_d   = 2'b01;
            state_d = S_DONE;
          end else if (stat_busy) begin
            if (int'(poll_q) >= int'(POLL_LIMIT) - 1) begin
              poll_d  = PW'(POLL_LIMIT);
              err_d   = 2'b10;
              state_d = S_DONE;
            end else begin
              poll_d = poll_q + 1'b1;
            end
          end else begin
            poll_d = '0;
            if (state_q == S_CHK_RX) begin
              state_d = S_READ;
            end else begin
              state_d   = S_WRITE;
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              awaddr_d  = BASE_ADDR;
              wdata_d   = {24'h0, tx_byte};
              wstrb_d   = 4'b0001;
            end
          end
        end
      end
      S_WRITE: begin
        if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && M_AXI_WREADY)   wvalid_d  = 1'b0;
        if (bready_q) begin
          if (M_AXI_BVALID) begin
            bready_d = 1'b0;
            wr_cnt_d = wr_cnt_q + 3'd1;
            if (wr_cnt_q == 3'd4) state_d = (len_q != 5'd0) ? S_CHK_RX : S_DONE;
            else                  state_d = S_CHK_TX;
          end
        end else if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      arg_q     <= '0;
      len_q     <= '0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      poll_q    <= '0;
      err_q     <= '0;
      resp_q    <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      arg_q     <= arg_d;
      len_q     <= len_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      poll_q    <= poll_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      araddr_q  <= araddr_d;
    end
  end

  assign M_AXI_AWADDR  = awaddr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_DONE);
  assign err           = err_q;
  assign resp          = resp_q;

endmodule

// File: tb/tb_sd_cmd_axi_master.sv
// tb_sd_cmd_axi_master
//   Random-delay AXI4-Lite slave emulating the SD register window, a
//   transaction-level reference model that predicts every bus access and the
//   final err/resp, and a monitor that checks observed traffic against it.
module tb_sd_cmd_axi_master;

  localparam logic [31:0] BASE  = 32'h4000_0100;
  localparam int          LIMIT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  AWADDR, WDATA, ARADDR;
  logic [31:0]  RDATA = '0;
  logic [3:0]   WSTRB;
  logic         AWVALID, WVALID, BREADY, ARVALID, RREADY;
  logic         AWREADY = 1'b0, WREADY = 1'b0, BVALID = 1'b0, ARREADY = 1'b0, RVALID = 1'b0;
  logic [1:0]   BRESP = 2'b10, RRESP = 2'b11;
  logic         cmd_start = 1'b0;
  logic [5:0]   cmd_index = '0;
  logic [31:0]  cmd_arg = '0;
  logic [4:0]   cmd_resp_len = '0;
  logic         busy, done;
  logic [1:0]   err;
  logic [135:0] resp;

  always #5 clk = ~clk;

  sd_cmd_axi_master #(.BASE_ADDR(BASE), .POLL_LIMIT(LIMIT)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rst_n),
    .M_AXI_AWADDR(AWADDR), .M_AXI_AWVALID(AWVALID), .M_AXI_AWREADY(AWREADY),
    .M_AXI_WDATA(WDATA), .M_AXI_WSTRB(WSTRB), .M_AXI_WVALID(WVALID), .M_AXI_WREADY(WREADY),
    .M_AXI_BRESP(BRESP), .M_AXI_BVALID(BVALID), .M_AXI_BREADY(BREADY),
    .M_AXI_ARADDR(ARADDR), .M_AXI_ARVALID(ARVALID), .M_AXI_ARREADY(ARREADY),
    .M_AXI_RDATA(RDATA), .M_AXI_RRESP(RRESP), .M_AXI_RVALID(RVALID), .M_AXI_RREADY(RREADY),
    .cmd_start(cmd_start), .cmd_index(cmd_index), .cmd_arg(cmd_arg),
    .cmd_resp_len(cmd_resp_len), .busy(busy), .done(done), .err(err), .resp(resp)
  );

  typedef struct { bit is_rd; logic [31:0] addr; logic [35:0] data; } xfer_t;
  typedef struct { logic [1:0] err; logic [135:0] resp; } res_t;

  xfer_t      exp_q[$];
  res_t       res_q[$];
  logic [7:0] st_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] st_dflt = 8'h00;
  logic [1:0] m_err = 2'b00;
  bit         hold_aw = 1'b0;
  int         n_total = 0;
  int         n_pass = 0;

  function automatic void chk(input string name, input logic [159:0] got, input logic [159:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, want);
  endfunction

  function automatic void miss(input string name);
    n_total++;
    $display("FAIL %s: event seen, expected none", name);
  endfunction

  // Transaction-level prediction: every status poll, write and rx read in
  // order, then the final error code and response.
  task automatic model(input logic [5:0] idx, input logic [31:0] arg, input logic [4:0] len,
                       input logic [7:0] st[$], input logic [7:0] rx[$]);
    logic [7:0]   cb [5];
    logic [135:0] r;
    logic [1:0]   e;
    logic [7:0]   s;
    int           nrx, polls;
    bit           go, is_tx;
    r = '0;
    e = 2'b00;
    cb[0] = {2'b01, idx}; cb[1] = arg[31:24]; cb[2] = arg[23:16]; cb[3] = arg[15:8]; cb[4] = arg[7:0];
    nrx = (len > 5'd17) ? 17 : int'(len);
    for (int b = 0; b < 5 + nrx && e == 2'b00; b++) begin
      is_tx = (b < 5);
      polls = 0;
      go = 1'b0;
      while (!go && e == 2'b00) begin
        s = (st.size() > 0) ? st.pop_front() : st_dflt;
        exp_q.push_back('{1'b1, BASE + 32'h10, 36'h0});
        if (s[5]) e = 2'b01;
        else if (is_tx ? s[0] : s[1]) begin
          polls++;
          if (polls == LIMIT) e = 2'b10;
        end else go = 1'b1;
      end
      if (go) begin
        if (is_tx) exp_q.push_back('{1'b0, BASE, {4'b0001, 24'h0, cb[b]}});
        else begin
          exp_q.push_back('{1'b1, BASE + 32'h04, 36'h0});
          r = {r[127:0], (b - 5 < rx.size()) ? rx[b - 5] : 8'hEE};
        end
      end
    end
    m_err = e;
    res_q.push_back('{e, r});
  endtask

  function automatic logic [31:0] rd_value(input logic [31:0] a);
    logic [31:0] v;
    v = $urandom;
    if (a == BASE + 32'h10)      v[7:0] = (st_q.size() > 0) ? st_q.pop_front() : st_dflt;
    else if (a == BASE + 32'h04) v[7:0] = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hEE;
    return v;
  endfunction

  // Slave: inputs change 1 time unit after the rising edge; handshakes at that
  // edge use the DUT outputs recorded one cycle earlier.
  logic        p_aw = 1'b0, p_w = 1'b0, p_b = 1'b0, p_ar = 1'b0, p_r = 1'b0;
  logic [31:0] p_araddr = '0, r_data = '0;
  bit          aw_ok = 1'b0, w_ok = 1'b0, r_pend = 1'b0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; ARREADY = 0; RVALID = 0;
      aw_ok = 0; w_ok = 0; r_pend = 0;
      p_aw = 0; p_w = 0; p_b = 0; p_ar = 0; p_r = 0;
    end else begin
      if (p_aw && AWREADY) aw_ok = 1;
      if (p_w && WREADY) w_ok = 1;
      if (BVALID && p_b) BVALID = 0;
      if (p_ar && ARREADY) begin r_pend = 1; r_data = rd_value(p_araddr); end
      if (RVALID && p_r) RVALID = 0;
      if (aw_ok && w_ok && !BVALID && $urandom_range(0, 2) != 0) begin
        BVALID = 1; aw_ok = 0; w_ok = 0;
      end
      if (r_pend && !RVALID && $urandom_range(0, 2) != 0) begin
        RVALID = 1; RDATA = r_data; r_pend = 0;
      end
      if (!RVALID) RDATA = $urandom;
      BRESP = 2'($urandom); RRESP = 2'($urandom);
      AWREADY = AWVALID && !hold_aw && ($urandom_range(0, 1) == 1);
      WREADY  = WVALID && ($urandom_range(0, 1) == 1);
      ARREADY = ARVALID && ($urandom_range(0, 1) == 1);
      p_aw = AWVALID; p_w = WVALID; p_b = BREADY; p_ar = ARVALID; p_r = RREADY;
      p_araddr = ARADDR;
    end
  end

  // Monitor: at the falling edge, VALID&READY means a handshake at the next
  // rising edge.
  bit          got_aw = 0, got_w = 0, pend_aw = 0, pend_w = 0, pend_ar = 0;
  logic [31:0] c_awaddr;
  logic [35:0] c_w;
  always @(negedge clk) begin
    xfer_t e;
    res_t  r;
    if (!rst_n) begin
      got_aw = 0; got_w = 0; pend_aw = 0; pend_w = 0; pend_ar = 0;
    end else begin
      if (pend_aw && !AWVALID) miss("awvalid_withdrawn");
      if (pend_w && !WVALID)   miss("wvalid_withdrawn");
      if (pend_ar && !ARVALID) miss("arvalid_withdrawn");
      if (ARVALID && (AWVALID || WVALID || BREADY)) miss("read_write_overlap");
      pend_aw = AWVALID && !AWREADY;
      pend_w  = WVALID && !WREADY;
      pend_ar = ARVALID && !ARREADY;
      if (AWVALID && AWREADY) begin got_aw = 1; c_awaddr = AWADDR; end
      if (WVALID && WREADY) begin got_w = 1; c_w = {WSTRB, WDATA}; end
      if (got_aw && got_w) begin
        got_aw = 0; got_w = 0;
        if (exp_q.size() == 0) miss("write_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("write", {1'b0, c_awaddr, c_w}, {e.is_rd, e.addr, e.data});
        end
      end
      if (ARVALID && ARREADY) begin
        if (exp_q.size() == 0) miss("read_unexpected");
        else begin
          e = exp_q.pop_front();
          chk("read", {1'b1, ARADDR}, {e.is_rd, e.addr});
        end
      end
      if (done) begin
        if (res_q.size() == 0) miss("done_unexpected");
        else begin
          r = res_q.pop_front();
          chk("result_err_resp", {busy, err, resp}, {1'b1, r.err, r.resp});
          chk("all_transfers_seen", exp_q.size(), 0);
        end
      end
    end
  end

  task automatic flush();
    exp_q.delete(); res_q.delete(); st_q.delete(); rx_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input logic [5:0] idx, input logic [31:0] arg, input logic [4:0] len,
                     input logic [7:0] st[$], input logic [7:0] dflt,
                     input logic [7:0] rx[$], input bit junk);
    int cyc;
    st_dflt = dflt;
    st_q = st;
    rx_q = rx;
    model(idx, arg, len, st, rx);
    @(negedge clk);
    cmd_index = idx; cmd_arg = arg; cmd_resp_len = len; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    cyc = 0;
    while (!done && cyc < 3000) begin
      if (junk) begin
        cmd_start = 1'($urandom); cmd_index = 6'($urandom);
        cmd_arg = $urandom; cmd_resp_len = 5'($urandom);
      end
      @(negedge clk);
      cyc++;
    end
    cmd_start = 1'b0;
    if (!done) begin
      chk("run_timeout", done, 1'b1);
      do_reset();
    end else begin
      @(negedge clk);
      chk("idle_after_done_err_held", {busy, done, err}, {2'b00, m_err});
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] sq[$];
    logic [7:0] rq[$];
    logic [7:0] s;
    int cyc;

    repeat (2) @(negedge clk);
    chk("reset_outputs", {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done, err,
                          AWADDR, ARADDR, WDATA, WSTRB}, '0);
    chk("reset_resp", resp, '0);
    rst_n = 1'b1;

    // CMD0, no response
    sq.delete(); rq.delete();
    run(6'd0, 32'h0, 5'd0, sq, 8'h02, rq, 1'b0);

    // CMD17 with six response bytes
    for (int i = 0; i < 6; i++) rq.push_back(8'(8'h11 + i));
    run(6'd17, 32'h0000_1234, 5'd6, sq, 8'h00, rq, 1'b0);

    // tx full for the first three polls
    rq.delete();
    repeat (3) sq.push_back(8'h01);
    run(6'd8, 32'h0000_01AA, 5'd0, sq, 8'h02, rq, 1'b0);

    // no disk
    sq.delete();
    run(6'd55, 32'hDEAD_BEEF, 5'd4, sq, 8'h20, rq, 1'b0);

    // rx never non-empty -> timeout in CHK_RX
    run(6'd41, 32'h40FF_8000, 5'd6, sq, 8'h02, rq, 1'b0);

    // tx always full -> timeout in CHK_TX
    run(6'd2, 32'h5, 5'd3, sq, 8'h01, rq, 1'b0);

    // length above 17 clamps; junk on cmd_* while busy must be ignored
    for (int i = 0; i < 20; i++) rq.push_back(8'($urandom));
    run(6'd9, $urandom, 5'd31, sq, 8'h00, rq, 1'b1);

    // reset while AW is stalled
    rq.delete();
    hold_aw = 1'b1;
    run_abort: begin
      st_dflt = 8'h02;
      model(6'd24, 32'h1234_5678, 5'd2, sq, rq);
      @(negedge clk);
      cmd_index = 6'd24; cmd_arg = 32'h1234_5678; cmd_resp_len = 5'd2; cmd_start = 1'b1;
      @(negedge clk);
      cmd_start = 1'b0;
      cyc = 0;
      while (!AWVALID && cyc < 100) begin @(negedge clk); cyc++; end
      chk("awvalid_before_reset", AWVALID, 1'b1);
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      flush();
      #1;
      chk("abort_outputs", {AWVALID, WVALID, BREADY, ARVALID, RREADY, busy, done, err,
                            AWADDR, ARADDR, WDATA, WSTRB}, '0);
      @(posedge clk); #1;
      chk("abort_resp_after_edge", {busy, done, resp}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      hold_aw = 1'b0;
    end
    for (int i = 0; i < 3; i++) rq.push_back(8'hA0 + 8'(i));
    run(6'd13, 32'hCAFE_F00D, 5'd3, sq, 8'h00, rq, 1'b0);

    // randomized commands and status sequences
    for (int t = 0; t < 25; t++) begin
      sq.delete(); rq.delete();
      for (int k = 0; k < 40; k++) begin
        s = 8'($urandom) & 8'hDC;
        if ($urandom_range(0, 3) == 0) s[0] = 1'b1;
        if ($urandom_range(0, 3) == 0) s[1] = 1'b1;
        if ($urandom_range(0, 59) == 0) s[5] = 1'b1;
        sq.push_back(s);
      end
      for (int k = 0; k < 17; k++) rq.push_back(8'($urandom));
      run(6'($urandom), $urandom, 5'($urandom), sq, 8'h00, rq, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sd_cmd_axi_master.md
SD_CMD_AXI_MASTER -- requirements
Module: sd_cmd_axi_master

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: base of the SD controller register window (tx_cmd 0x00, rx_cmd 0x04, status 0x10).
REQ-002 The block SHALL have parameter POLL_LIMIT, default 1023: maximum unsuccessful status polls per wait before timeout.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port M_AXI_ACLK, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port M_AXI_ARESETN, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have write-address ports M_AXI_AWADDR (out, 32), M_AXI_AWVALID (out, 1) and M_AXI_AWREADY (in, 1).
REQ-007 The block SHALL have write-data ports M_AXI_WDATA (out, 32), M_AXI_WSTRB (out, 4), M_AXI_WVALID (out, 1) and M_AXI_WREADY (in, 1).
REQ-008 The block SHALL have write-response ports M_AXI_BRESP (in, 2, ignored), M_AXI_BVALID (in, 1) and M_AXI_BREADY (out, 1).
REQ-009 The block SHALL have read-address ports M_AXI_ARADDR (out, 32), M_AXI_ARVALID (out, 1) and M_AXI_ARREADY (in, 1).
REQ-010 The block SHALL have read-data ports M_AXI_RDATA (in, 32), M_AXI_RRESP (in, 2, ignored), M_AXI_RVALID (in, 1) and M_AXI_RREADY (out, 1).
REQ-011 The block SHALL have port cmd_start, input, 1 bit: request pulse, sampled only in IDLE.
REQ-012 The block SHALL have port cmd_index, input, 6 bits: SD command index.
REQ-013 The block SHALL have port cmd_arg, input, 32 bits: SD command argument.
REQ-014 The block SHALL have port cmd_resp_len, input, 5 bits: response bytes to collect, 0..17; values above 17 are treated as 17.
REQ-015 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-017 The block SHALL have port err, output, 2 bits: 00 ok, 01 no disk, 10 timeout; valid while done is high and held until the next start.
REQ-018 The block SHALL have port resp, output, 136 bits: collected response bytes, last byte received at bits [7:0].

Function
REQ-019 The state machine SHALL have states IDLE, CHK_TX, WRITE, CHK_RX, READ and DONE.
REQ-020 IDLE with cmd_start high SHALL latch index, arg and len, clear resp and the byte/poll counters, and go to CHK_TX.
REQ-021 cmd_start SHALL be ignored while busy is high.
REQ-022 The byte sequence written SHALL be {2'b01,cmd_index}, arg[31:24], arg[23:16], arg[15:8], arg[7:0], each to BASE_ADDR+0x00.
REQ-023 WDATA SHALL be {24'h0, byte} and WSTRB SHALL be 4'b0001.
REQ-024 CHK_TX SHALL issue one status read at BASE_ADDR+0x10.
REQ-025 In CHK_TX, if status bit5 is set, the block SHALL set err=01 and go to DONE.
REQ-026 In CHK_TX, else if status bit0 (tx full) is set, the block SHALL increment the poll count and repeat CHK_TX; when the count reaches POLL_LIMIT it SHALL set err=10 and go to DONE.
REQ-027 In CHK_TX, otherwise the block SHALL clear the poll count and go to WRITE.
REQ-028 WRITE SHALL assert AWVALID and WVALID in the same cycle and drop each independently on its own READY.
REQ-029 WRITE SHALL hold BREADY high until BVALID is seen, then either return to CHK_TX for the next byte or, after byte 5, go to CHK_RX if len>0 and to DONE otherwise.
REQ-030 CHK_RX SHALL issue a status read and apply the same nodisk and timeout rules as CHK_TX, polling on bit1 (rx empty) instead of bit0.
REQ-031 In CHK_RX, bit1 clear SHALL clear the poll count and move to READ.
REQ-032 READ SHALL read BASE_ADDR+0x04 and shift resp left by 8, inserting RDATA[7:0] at bits [7:0].
REQ-033 READ SHALL go to CHK_RX while fewer than len bytes have been received, and to DONE otherwise.
REQ-034 Every AXI read SHALL hold ARVALID until ARREADY, then hold RREADY high until RVALID; data SHALL be captured on RVALID&RREADY.
REQ-035 At most one AXI transaction SHALL be outstanding at any time.
REQ-036 A VALID signal SHALL never be withdrawn before its READY, except by reset.
REQ-037 DONE SHALL pulse done for one cycle and return to IDLE on the next cycle.
REQ-038 The poll counter SHALL saturate and never wrap.

Reset
REQ-039 While M_AXI_ARESETN is low, all VALID and READY outputs, busy, done, err, resp, the counters and the AWADDR/ARADDR/WDATA/WSTRB outputs SHALL be 0, and the state SHALL be IDLE.
REQ-040 Reset asserted mid-transaction SHALL abandon the transaction immediately with no completion pulse.

Verification
REQ-041 The bench SHALL cover: CMD0, arg 0, len 0, status 0x02 -> five writes 0x40,0x00,0x00,0x00,0x00 to 0x00; then done with err=00.
REQ-042 The bench SHALL cover: CMD17, arg 0x0000_1234, len 6, model rx bytes 0x11..0x16 -> writes 0x51,00,00,12,34; resp[47:0]=0x111213141516; err=00.
REQ-043 The bench SHALL cover: status bit0 set for the first 3 polls before byte 1 -> exactly 3 extra status reads, then a normal sequence.
REQ-044 The bench SHALL cover: status 0x20 -> err=01, zero writes, done after one status read.
REQ-045 The bench SHALL cover: POLL_LIMIT=4, rx never non-empty, len 6 -> four CHK_RX polls, then err=10.
REQ-046 The bench SHALL cover: reset pulsed while AWVALID is high, AWREADY held low -> all outputs 0 next edge; a subsequent start runs cleanly.
